lfsr_seg_rnd_seq: RTL and testbench

- Sequential, parametrised successor to the combinational segment randomiser.
- Produces one NB_SEGMENTS-wide "segment ON" vector per request from an internal Fibonacci LFSR, computing one segment per clock to bound logic depth.
- The display-probability threshold and fine-tune mask are applied per segment.
- Sits between the seed source and the bitmap/segment display garbling logic. The LFSR state persists across requests, so consecutive frames differ without reseeding.

---
 rtl/lfsr_seg_rnd_seq.sv | 81 ++++++++
 tb/tb_lfsr_seg_rnd_seq.sv | 129 ++++++++++++
 2 files changed

// File: rtl/lfsr_seg_rnd_seq.sv
// lfsr_seg_rnd_seq: per-request segment ON vector from a Fibonacci LFSR, one segment per clock.
module lfsr_seg_rnd_seq #(
  parameter int NB_SEGMENTS = 7,
  parameter int SLICE_BITS = 10,
  parameter int LFSR_WIDTH = 32,
  parameter int COUNTER_WIDTH = 4,
  parameter logic [LFSR_WIDTH-1:0] TAPS = 32'h8000_000D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     reseed,
  input  logic [LFSR_WIDTH-1:0]    seed,
  input  logic [COUNTER_WIDTH-1:0] probability,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NB_SEGMENTS-1:0]   rnd
);
  localparam int IDX_W = $clog2(NB_SEGMENTS + 1);
  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;
  state_t state_q, state_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d, step;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [COUNTER_WIDTH-1:0] thr_q, thr_d, cnt;
  logic [NB_SEGMENTS-1:0] rnd_q, rnd_d;
  logic [SLICE_BITS-1:0] mask, slice;
  assign mask = thr_q == COUNTER_WIDTH'(4) ? SLICE_BITS'(1) :
                thr_q == COUNTER_WIDTH'(5) ? SLICE_BITS'(3) :
                thr_q == COUNTER_WIDTH'(6) ? SLICE_BITS'(7) : '0;
  assign slice = lfsr_q[SLICE_BITS-1:0] | mask;
  always_comb begin
    step = lfsr_q;
    cnt = '0;
    for (int i = 0; i < SLICE_BITS; i++) step = {step[LFSR_WIDTH-2:0], ^(step & TAPS)};
    for (int i = 0; i < SLICE_BITS; i++) cnt = cnt + COUNTER_WIDTH'(slice[i]);
  end
  // GEN runs one drain cycle after the last segment so DONE lands NB_SEGMENTS+1 edges after acceptance
  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_q;
    idx_d = idx_q;
    thr_d = thr_q;
    rnd_d = rnd_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = GEN;
        thr_d = probability;
        idx_d = '0;
        rnd_d = '0;
        if (reseed) lfsr_d = seed == '0 ? LFSR_WIDTH'(1) : seed;
      end
      GEN: if (idx_q == IDX_W'(NB_SEGMENTS)) state_d = DONE;
      else begin
        rnd_d[idx_q] = (thr_q == '0) | (cnt > thr_q);
        lfsr_d = step;
        idx_d = idx_q + IDX_W'(1);
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q <= LFSR_WIDTH'(1);
      idx_q <= '0;
      thr_q <= '0;
      rnd_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      idx_q <= idx_d;
      thr_q <= thr_d;
      rnd_q <= rnd_d;
    end
  end
  assign busy = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign rnd = rnd_q;
endmodule

// File: tb/tb_lfsr_seg_rnd_seq.sv
// tb_lfsr_seg_rnd_seq: directed checks of lfsr_seg_rnd_seq against hand values and a small LFSR model.
module tb_lfsr_seg_rnd_seq;
  logic clk = 0, rst = 1, start = 0, reseed = 0, out_ready = 0;
  logic [31:0] seed = '0;
  logic [3:0] probability = '0;
  logic busy, out_valid;
  logic [6:0] rnd;
  int n_checks = 0, n_err = 0;
  logic [31:0] m_lfsr;
  logic [6:0] got, exp_r, held;
  int lat;
  always #5 clk = ~clk;
  lfsr_seg_rnd_seq dut (.clk(clk), .rst(rst), .start(start), .reseed(reseed), .seed(seed),
    .probability(probability), .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .rnd(rnd));
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_frame(input logic [3:0] thr, output logic [6:0] r);
    logic [9:0] sl;
    for (int k = 0; k < 7; k++) begin
      sl = m_lfsr[9:0] | (thr == 4 ? 10'h001 : thr == 5 ? 10'h003 : thr == 6 ? 10'h007 : 10'h000);
      r[k] = (thr == 0) || ($countones(sl) > int'(thr));
      for (int j = 0; j < 10; j++) m_lfsr = {m_lfsr[30:0], ^(m_lfsr & 32'h8000_000D)};
    end
  endtask
  task automatic request(input logic rs, input logic [31:0] sd, input logic [3:0] pr);
    @(negedge clk);
    start = 1; reseed = rs; seed = sd; probability = pr;
    @(posedge clk); #1;
    start = 0; reseed = 0; seed = '0; probability = '0;
  endtask
  task automatic run_frame(input logic rs, input logic [31:0] sd, input logic [3:0] pr, output logic [6:0] r);
    request(rs, sd, pr);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    r = rnd;
  endtask
  task automatic release_frame();
    @(negedge clk);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("released_valid", {31'd0, out_valid}, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_rnd", {25'd0, rnd}, 0);
    m_lfsr = 32'd1;
    model_frame(4'd5, exp_r);
    run_frame(0, '0, 4'd5, got);
    check("after_rst_lfsr1", {25'd0, got}, {25'd0, exp_r});
    release_frame();
    check("idle_busy", {31'd0, busy}, 0);
    run_frame(1, 32'd0, 4'd0, got);
    check("latency", lat, 8);
    check("thr0_all_on", {25'd0, got}, 32'h7F);
    check("done_busy", {31'd0, busy}, 1);
    release_frame();
    m_lfsr = 32'd1;
    model_frame(4'd2, exp_r);
    run_frame(1, 32'd0, 4'd2, got);
    check("seed0_loads1", {25'd0, got}, {25'd0, exp_r});
    release_frame();
    check("rnd_held_idle", {25'd0, rnd}, {25'd0, exp_r});
    m_lfsr = 32'h0000_03FF;
    model_frame(4'd9, exp_r);
    run_frame(1, 32'h0000_03FF, 4'd9, got);
    check("thr9_seg0", {31'd0, got[0]}, 1);
    check("thr9_model", {25'd0, got}, {25'd0, exp_r});
    release_frame();
    run_frame(1, 32'h0000_03FF, 4'd15, got);
    check("thr15_all_off", {25'd0, got}, 0);
    held = got;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = i[0]; reseed = 1; seed = $urandom; probability = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      check("bp_valid", {31'd0, out_valid}, 1);
      check("bp_rnd", {25'd0, rnd}, {25'd0, held});
    end
    start = 0; reseed = 0;
    release_frame();
    check("bp_idle_busy", {31'd0, busy}, 0);
    m_lfsr = 32'hACE1_0001;
    model_frame(4'd4, exp_r);
    run_frame(1, 32'hACE1_0001, 4'd4, got);
    check("chain_f0", {25'd0, got}, {25'd0, exp_r});
    release_frame();
    model_frame(4'd6, exp_r);
    run_frame(0, 32'h1234_5678, 4'd6, got);
    check("chain_f1", {25'd0, got}, {25'd0, exp_r});
    release_frame();
    model_frame(4'd3, exp_r);
    run_frame(0, 32'hFFFF_FFFF, 4'd3, got);
    check("chain_f2", {25'd0, got}, {25'd0, exp_r});
    release_frame();
    request(1, 32'hDEAD_BEEF, 4'd7);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("midgen_busy", {31'd0, busy}, 0);
    check("midgen_rnd", {25'd0, rnd}, 0);
    lat = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat++;
    end
    check("midgen_no_valid", lat, 0);
    m_lfsr = 32'd1;
    model_frame(4'd3, exp_r);
    run_frame(0, 32'h5555_5555, 4'd3, got);
    check("post_rst_lfsr1", {25'd0, got}, {25'd0, exp_r});
    check("post_rst_latency", lat, 8);
    release_frame();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
